eight_bit_divider: RTL and testbench
====================================

// Module: eight_bit_divider
// PURPOSE
//  Sequential unsigned restoring divider for the mini-calculator datapath.
//  - Forms Quotient = Dividend / Divisor and Remainder = Dividend % Divisor.
//  - Produces one quotient bit per clock, using trial subtraction R + ~D + 1 on the carry-chain adder.
//  - Sits beside the adder/subtractor in the ALU.
//  - start/busy/done handshake toward the calculator control FSM.
// PARAMETERS
//  N   8   operand/result width in bits (N >= 2)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   request; sampled only in IDLE
//  Dividend     in   N   numerator, captured when start is accepted
//  Divisor      in   N   denominator, captured when start is accepted
//  Quotient     out  N   result, valid from done until the next accepted start
//  Remainder    out  N   result, valid from done until the next accepted start
//  busy         out  1   high while a division is in progress (CALC, DONE)
//  done         out  1   one-cycle pulse; results valid in that cycle
//  div_by_zero  out  1   set with done when the captured Divisor == 0
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is asynchronous and active-high.
//  - In reset: state = IDLE; Quotient, Remainder, busy, done, div_by_zero = 0.
//  - Reset mid-operation aborts immediately. Partial results are discarded.
//  FSM: IDLE -> CALC -> DONE -> IDLE
//  - IDLE:
//    - If start = 1 at an edge, capture the operands.
//    - Clear the partial remainder P ((N+1) bits) to 0. Set cnt = N-1.
//    - Go to CALC.
//  - CALC, each cycle:
//    - P = {P[N-1:0], Q_sh[N-1]}; shift Q_sh left.
//    - T = P - {0, D} via the adder (~D, Cin = 1). Carry-out = 1 means no borrow.
//    - No borrow: P = T, Q_sh[0] = 1. Borrow: P is kept, Q_sh[0] = 0.
//    - When cnt == 0, go to DONE; otherwise decrement cnt.
//  - DONE:
//    - Register Quotient = Q_sh and Remainder = P[N-1:0].
//    - Assert done = 1 for exactly this cycle. Go to IDLE.
//  Latency and handshake
//  - Start accepted at edge t: busy = 1 from t+1; done = 1 in cycle t+N+1.
//  - busy falls together with done.
//  - start while busy is ignored. No queueing. Operands are not re-sampled.
//  - start held high continuously gives back-to-back divisions.
//  - The next division is accepted on the first IDLE edge after done.
//  - Quotient and Remainder hold their value across IDLE. They change only in DONE.
//  Arithmetic and boundaries
//  - Unsigned only. Remainder < Divisor always holds when Divisor != 0.
//  - Divisor > Dividend: Quotient = 0, Remainder = Dividend.
//  - Divisor == 1: Quotient = Dividend, Remainder = 0.
//  - Divisor == 0 (natural restoring result): Quotient = all ones, Remainder = Dividend.
//  - div_by_zero is valid only while done = 1; it is 0 otherwise.
// CONFIGURATION
//  DIV_ZERO_SHORTCUT_EN
//  - Defined:
//    - A zero Divisor at capture goes IDLE -> DONE directly, skipping CALC.
//    - DONE forces Quotient = all ones and Remainder = Dividend.
//    - done and div_by_zero = 1 in cycle t+1.
//  - Undefined:
//    - A zero Divisor runs the full N CALC cycles; done in cycle t+N+1.
//    - Same Quotient/Remainder values. div_by_zero still asserts with done.
//  - Non-zero divisors behave identically either way.
// STRUCTURE
//  - Package div_pkg:
//    - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t
//    - localparam DIV_W = 8
//    - function clog2-based counter width
//  - Sub-module: one instance of the existing parameterized ripple adder.
//    - Parameter N+1, B = ~{1'b0, Divisor}, Cin = 1.
//    - Serves as the trial subtractor. No new sub-module is required.
// TESTING
//  1. 200 / 7 -> Quotient = 28, Remainder = 4, done exactly 9 cycles after start, busy high for 9 cycles.
//  2. 255 / 1 -> 255, 0. Then 5 / 9 -> 0, 5, issued back to back with start held high.
//  3. 77 / 0 -> Quotient = 255, Remainder = 77, div_by_zero = 1 with done.
//     - Macro defined: done at cycle t+1. Macro undefined: done at t+9.
//  4. 100 / 10 started, then start pulsed with 3 / 3 at cycle 4 -> ignored.
//     - Result is 10, 0. Outputs keep 10, 0 through 5 idle cycles.
//  5. rst asserted during CALC cycle 5 of 250 / 3 -> outputs = 0 asynchronously, state = IDLE.
//     - A new 9 / 2 then returns 4, 1 with normal latency.
//  6. Random sweep of 2000 operand pairs vs. a reference model. Checks:
//     - Q*D + R == A and R < D
//     - done is a one-cycle pulse

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W = 8;

    // Counter must hold n-1; never narrower than one bit.
    function automatic int div_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eight_bit_divider_ripple_adder.sv
// rtl/eight_bit_divider_ripple_adder.sv - parameterized ripple-carry adder used as the trial subtractor
module eight_bit_divider_ripple_adder #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic carry;

    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/eight_bit_divider.sv
// rtl/eight_bit_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional build macro DIV_ZERO_SHORTCUT_EN: zero divisor skips the CALC phase.
module eight_bit_divider
    import div_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = div_cnt_w(N);

    div_state_t    state;
    logic [N:0]    p;
    logic [N-1:0]  q_sh;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic          d_zero;

    logic [N:0]    p_shift;
    logic [N:0]    b_inv;
    logic [N:0]    trial;
    logic          no_borrow;
    logic          unused_p_msb;

    // The kept remainder is always below the divisor, so P's top bit never feeds the next shift.
    assign p_shift      = {p[N-1:0], q_sh[N-1]};
    assign b_inv        = ~{1'b0, d};
    assign unused_p_msb = p[N];

    eight_bit_divider_ripple_adder #(
        .W(N + 1)
    ) u_trial_sub (
        .a   (p_shift),
        .b   (b_inv),
        .cin (1'b1),
        .sum (trial),
        .cout(no_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p           <= '0;
            q_sh        <= '0;
            d           <= '0;
            cnt         <= '0;
            d_zero      <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start) begin
                        d      <= Divisor;
                        q_sh   <= Dividend;
                        p      <= '0;
                        cnt    <= CW'(N - 1);
                        d_zero <= (Divisor == '0);
`ifdef DIV_ZERO_SHORTCUT_EN
                        state  <= (Divisor == '0) ? DONE : CALC;
`else
                        state  <= CALC;
`endif
                    end
                end
                CALC: begin
                    busy <= 1'b1;
                    p    <= no_borrow ? trial : p_shift;
                    q_sh <= {q_sh[N-2:0], no_borrow};
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy        <= 1'b1;
                    done        <= 1'b1;
                    div_by_zero <= d_zero;
`ifdef DIV_ZERO_SHORTCUT_EN
                    // Skipped CALC leaves the dividend untouched in q_sh.
                    if (d_zero) begin
                        Quotient  <= '1;
                        Remainder <= q_sh;
                    end else begin
                        Quotient  <= q_sh;
                        Remainder <= p[N-1:0];
                    end
`else
                    Quotient  <= q_sh;
                    Remainder <= p[N-1:0];
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eight_bit_divider.sv
// tb/tb_eight_bit_divider.sv - scoreboard bench for eight_bit_divider with randomized reference checks
module tb_eight_bit_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    eight_bit_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .Dividend   (dividend),
        .Divisor    (divisor),
        .Quotient   (quotient),
        .Remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int d;
        int q;
        int r;
        int dz;
        int when;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   next_free = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; zero divisor yields all ones and the dividend.
    task automatic issue(input int a, input int d, input bit hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        while (cyc < next_free) @(negedge clk);
        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 8'(d);
        lat = N + 1;
`ifdef DIV_ZERO_SHORTCUT_EN
        if (d == 0) lat = 1;
`endif
        e.a    = a;
        e.d    = d;
        e.q    = (d == 0) ? 255 : a / d;
        e.r    = (d == 0) ? a : a % d;
        e.dz   = (d == 0) ? 1 : 0;
        e.when = cyc + 1 + lat;
        sb.push_back(e);
        next_free = e.when;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                check("done_one_cycle", {31'd0, prev_done}, 0);
                check("busy_with_done", {31'd0, busy}, 1);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {24'd0, quotient}, e.q);
                    check("remainder", {24'd0, remainder}, e.r);
                    check("div_by_zero", {31'd0, div_by_zero}, e.dz);
                    check("latency", cyc, e.when);
                    if (e.d != 0) begin
                        check("q_times_d_plus_r", quotient * e.d + remainder, e.a);
                        check("r_below_d", {31'd0, (int'(remainder) < e.d)}, 1);
                    end
                end
            end else begin
                check("dbz_without_done", {31'd0, div_by_zero}, 0);
            end
        end
        prev_done = done;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int bc;
        int a;
        int d;
        int sel;

        repeat (2) @(negedge clk);
        check("rst_quotient", {24'd0, quotient}, 0);
        check("rst_remainder", {24'd0, remainder}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_dbz", {31'd0, div_by_zero}, 0);
        rst = 1'b0;

        issue(200, 7, 1'b0);
        bc = 0;
        for (int i = 0; i < 13; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("busy_cycles", bc, 9);

        issue(255, 1, 1'b1);
        issue(5, 9, 1'b0);

        issue(77, 0, 1'b0);

        issue(100, 10, 1'b0);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd3;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        while (cyc < next_free) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_quotient", {24'd0, quotient}, 10);
            check("hold_remainder", {24'd0, remainder}, 0);
            check("hold_busy", {31'd0, busy}, 0);
        end

        issue(250, 3, 1'b0);
        while (cyc < next_free - 5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_quotient", {24'd0, quotient}, 0);
        check("abort_remainder", {24'd0, remainder}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        sb.delete();
        next_free = 0;
        @(negedge clk);
        rst = 1'b0;
        issue(9, 2, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            a   = $urandom_range(0, 255);
            sel = $urandom_range(0, 7);
            if (sel == 0)      d = 0;
            else if (sel == 1) d = 1;
            else if (sel == 2) d = $urandom_range(a, 255);
            else               d = $urandom_range(1, 255);
            issue(a, d, (i != 1999) && ($urandom_range(0, 1) == 1));
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
